// File: rtl/multichannel_moving_average_pkg.sv
// rtl/multichannel_moving_average_pkg.sv - shared types and helpers for the moving-average filter
package multichannel_moving_average_pkg;

   // Control states: filling the window, steady-state output, one-cycle flush
   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   // Ceiling log2, usable in parameter and port-width expressions
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Accumulator width: a full window of max-depth samples cannot overflow
   function automatic int out_width(input int in_w, input int log2_depth);
      return in_w + log2_depth;
   endfunction

endpackage

// File: rtl/multichannel_moving_average_delay_line.sv
// rtl/multichannel_moving_average_delay_line.sv - circular sample buffer, one write port, async read port
module avg_delay_line
   import multichannel_moving_average_pkg::*;
#(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 64,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage needs no reset: fill gating masks stale contents
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read-before-write: the slot about to be overwritten is still visible this cycle
   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/multichannel_moving_average.sv
// rtl/multichannel_moving_average.sv - NCHAN boxcar sum/mean filter with run-time window 2^k
module multichannel_moving_average
   import multichannel_moving_average_pkg::*;
#(
   parameter int  IN_WIDTH       = 16,
   parameter int  NCHAN          = 2,
   parameter int  LOG2_MAX_DEPTH = 6,
   localparam int OUT_WIDTH      = out_width(IN_WIDTH, LOG2_MAX_DEPTH),
   localparam int LW             = clog2(LOG2_MAX_DEPTH + 1)
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic                       in_valid,
   input  logic [NCHAN*IN_WIDTH-1:0]  in_data,
   input  logic [LW-1:0]              log2_len,
   input  logic                       mean_mode,
   input  logic                       clear,
   output logic                       out_valid,
   output logic [NCHAN*OUT_WIDTH-1:0] out_data,
   output logic                       primed,
   output logic                       busy
);

   localparam int AW = LOG2_MAX_DEPTH;
   localparam int CW = LOG2_MAX_DEPTH + 1;

   state_e        state_q, state_d;
   logic [LW-1:0] k_q, k_d, k_clamp, k_cur;
   logic          k_loaded_q, k_loaded_d;
   logic [AW-1:0] wp_q, wp_d, rd_addr;
   logic [CW-1:0] fill_cnt_q, fill_cnt_d, fill_inc, n_len;
   logic          flush_req, accept, emit, use_old, out_valid_q;

   assign k_clamp = (int'(log2_len) > LOG2_MAX_DEPTH) ? LW'(LOG2_MAX_DEPTH) : log2_len;
   // Before the first post-reset edge has latched k, the live request is the window
   assign k_cur     = k_loaded_q ? k_q : k_clamp;
   assign n_len     = CW'(1) << k_cur;
   assign fill_inc  = fill_cnt_q + CW'(1);
   // Truncation makes a full-depth window read the slot at wp itself
   assign rd_addr   = wp_q - n_len[AW-1:0];
   assign use_old   = (fill_cnt_q >= n_len);
   assign flush_req = (state_q != ST_FLUSH) && (clear || (k_loaded_q && (k_clamp != k_q)));
   assign accept    = in_valid && (state_q != ST_FLUSH) && !flush_req;
   assign emit      = accept && ((state_q == ST_RUN) || (fill_inc == n_len));

   // Next-state logic for FSM, write pointer, fill counter and window exponent
   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      k_loaded_d = k_loaded_q;
      wp_d       = wp_q;
      fill_cnt_d = fill_cnt_q;
      if (!k_loaded_q) begin
         k_d        = k_clamp;
         k_loaded_d = 1'b1;
      end
      case (state_q)
         ST_FILL: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
            end else if (accept) begin
               fill_cnt_d = fill_inc;
               wp_d       = wp_q + AW'(1);
               if (fill_inc == n_len) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
            end else if (accept) begin
               wp_d = wp_q + AW'(1);
            end
         end
         ST_FLUSH: begin
            wp_d       = '0;
            fill_cnt_d = '0;
            k_d        = k_clamp;
            state_d    = ST_FILL;
         end
         default: state_d = ST_FILL;
      endcase
   end

   // Control state registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_FILL;
         k_q         <= '0;
         k_loaded_q  <= 1'b0;
         wp_q        <= '0;
         fill_cnt_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         k_loaded_q  <= k_loaded_d;
         wp_q        <= wp_d;
         fill_cnt_q  <= fill_cnt_d;
         out_valid_q <= emit;
      end
   end

   assign out_valid = out_valid_q;
   assign primed    = (state_q == ST_RUN);
   assign busy      = (state_q == ST_FLUSH);

   for (genvar c = 0; c < NCHAN; c++) begin : g_chan
      logic signed [IN_WIDTH-1:0]  x, old;
      logic signed [OUT_WIDTH-1:0] x_ext, old_ext, acc_q, acc_d, bias, mean_v, out_q;

      assign x = in_data[c*IN_WIDTH +: IN_WIDTH];

      avg_delay_line #(
         .WIDTH (IN_WIDTH),
         .DEPTH (1 << LOG2_MAX_DEPTH)
      ) u_delay_line (
         .clk_i   (clock),
         .we_i    (accept),
         .waddr_i (wp_q),
         .wdata_i (x),
         .raddr_i (rd_addr),
         .rdata_o (old)
      );

      assign x_ext   = OUT_WIDTH'(x);
      assign old_ext = use_old ? OUT_WIDTH'(old) : '0;
      assign acc_d   = acc_q + x_ext - old_ext;
      // Half-LSB bias before the arithmetic shift rounds ties toward +inf; zero when k = 0
      assign bias    = (OUT_WIDTH'(1) << k_cur) >> 1;
      assign mean_v  = (acc_d + bias) >>> k_cur;

      // Running window sum and held output value for this channel
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            acc_q <= '0;
            out_q <= '0;
         end else begin
            if (state_q == ST_FLUSH) begin
               acc_q <= '0;
            end else if (accept) begin
               acc_q <= acc_d;
            end
            if (emit) begin
               out_q <= mean_mode ? mean_v : acc_d;
            end
         end
      end

      assign out_data[c*OUT_WIDTH +: OUT_WIDTH] = out_q;
   end

endmodule

// File: tb/tb_multichannel_moving_average.sv
// tb/tb_multichannel_moving_average.sv - self-checking bench for multichannel_moving_average
module tb_multichannel_moving_average;

   localparam int IW = 16;
   localparam int NC = 2;
   localparam int LD = 6;
   localparam int OW = IW + LD;
   localparam int LW = 3;

   logic              clock = 1'b0;
   logic              reset_n = 1'b1;
   logic              in_valid = 1'b0;
   logic [NC*IW-1:0]  in_data = '0;
   logic [LW-1:0]     log2_len = 3'd2;
   logic              mean_mode = 1'b0;
   logic              clear = 1'b0;
   logic              out_valid;
   logic [NC*OW-1:0]  out_data;
   logic              primed;
   logic              busy;

   always #5 clock = ~clock;

   multichannel_moving_average #(
      .IN_WIDTH       (IW),
      .NCHAN          (NC),
      .LOG2_MAX_DEPTH (LD)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .log2_len  (log2_len),
      .mean_mode (mean_mode),
      .clear     (clear),
      .out_valid (out_valid),
      .out_data  (out_data),
      .primed    (primed),
      .busy      (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: sample history per channel since the last fill start
   longint hist [NC][$];
   bit     m_loaded, m_flush, m_primed, m_valid;
   int     m_k;
   longint m_out [NC];

   task automatic check(input string tag, input longint obs, input longint exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampk(input int v);
      return (v > LD) ? LD : v;
   endfunction

   function automatic longint round_mean(input longint s, input int k);
      longint d, a, q;
      if (k == 0) return s;
      d = longint'(1) << k;
      a = s + d / 2;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      return q;
   endfunction

   function automatic longint och(input int c);
      logic signed [OW-1:0] t;
      t = out_data[c*OW +: OW];
      return longint'(t);
   endfunction

   function automatic longint rand16();
      logic signed [IW-1:0] r;
      r = IW'($urandom);
      return longint'(r);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) begin
         hist[c].delete();
         m_out[c] = 0;
      end
      m_loaded = 0;
      m_flush  = 0;
      m_primed = 0;
      m_valid  = 0;
      m_k      = 0;
   endtask

   task automatic check_all(input string tag);
      check({tag, "_out_valid"}, longint'(out_valid), longint'(m_valid));
      check({tag, "_busy"}, longint'(busy), longint'(m_flush));
      check({tag, "_primed"}, longint'(primed), longint'(m_primed));
      check({tag, "_ch0"}, och(0), m_out[0]);
      check({tag, "_ch1"}, och(1), m_out[1]);
   endtask

   task automatic step(input bit v, input longint d0, input longint d1, input int len,
                       input bit mm, input bit clr, input string tag);
      int     kc, n, sz;
      bit     fr;
      longint s;
      in_valid  = v;
      in_data   = {IW'(d1), IW'(d0)};
      log2_len  = LW'(len);
      mean_mode = mm;
      clear     = clr;
      @(posedge clock);
      #1;
      m_valid = 0;
      if (m_flush) begin
         m_flush = 0;
         m_k     = clampk(len);
         for (int c = 0; c < NC; c++) hist[c].delete();
      end else begin
         kc = m_loaded ? m_k : clampk(len);
         fr = clr || (m_loaded && (clampk(len) != m_k));
         m_loaded = 1;
         m_k      = kc;
         if (fr) begin
            m_flush  = 1;
            m_primed = 0;
         end else if (v) begin
            hist[0].push_back(d0);
            hist[1].push_back(d1);
            for (int c = 0; c < NC; c++) if (hist[c].size() > 64) void'(hist[c].pop_front());
            n = 1 << kc;
            if (hist[0].size() >= n) begin
               m_valid  = 1;
               m_primed = 1;
               for (int c = 0; c < NC; c++) begin
                  s  = 0;
                  sz = hist[c].size();
                  for (int j = sz - n; j < sz; j++) s += hist[c][j];
                  m_out[c] = mm ? round_mean(s, kc) : s;
               end
            end
         end
      end
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      #3;
      reset_n = 1'b0;
      #1;
      model_reset();
      check({tag, "_rst_out_valid"}, longint'(out_valid), 0);
      check({tag, "_rst_ch0"}, och(0), 0);
      check({tag, "_rst_ch1"}, och(1), 0);
      check({tag, "_rst_primed"}, longint'(primed), 0);
      check({tag, "_rst_busy"}, longint'(busy), 0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   initial begin
      #2;
      do_reset("init");

      // Sum mode, k=2: outputs 10, 14, 18 from the fourth sample on
      for (int i = 1; i <= 6; i++) begin
         step(1, i, rand16(), 2, 0, 0, "sum_k2");
         if (i == 4) check("sum_k2_first", och(0), 10);
         if (i == 6) check("sum_k2_last", och(0), 18);
      end

      // Mean mode after a clear: constant -7 and +32767
      step(0, 0, 0, 2, 1, 1, "mean_clr");
      step(1, 5, 5, 2, 1, 0, "mean_flush");
      for (int i = 0; i < 6; i++) step(1, -7, 32767, 2, 1, 0, "mean_const");
      check("mean_ch0_const", och(0), -7);
      check("mean_ch1_const", och(1), 32767);
      step(1, -7, 32767, 2, 0, 0, "sum_const");
      check("sum_ch1_max", och(1), 131068);

      // Full-depth window with a ramp
      step(0, 0, 0, 6, 0, 0, "k6_change");
      step(0, 0, 0, 6, 0, 0, "k6_flush");
      for (int i = 0; i < 128; i++) begin
         step(1, i, rand16(), 6, 0, 0, "ramp_k6");
         if (i == 63) check("ramp_first", och(0), 2016);
         if (i == 127) check("ramp_last", och(0), 6112);
      end

      // Window change in RUN with a simultaneous sample
      step(1, 5, 5, 1, 0, 0, "k1_change");
      step(1, 9, 9, 1, 0, 0, "k1_flush");
      step(1, 3, 4, 1, 0, 0, "k1_fill");
      step(1, 6, 7, 1, 0, 0, "k1_out");
      check("k1_refill_ch0", och(0), 9);
      check("k1_refill_ch1", och(1), 11);

      // Mean rounding at k=1
      step(0, 0, 0, 1, 1, 1, "rnd_clr");
      step(0, 0, 0, 1, 1, 0, "rnd_flush");
      step(1, 1, 1, 1, 1, 0, "rnd_a");
      step(1, 2, 2, 1, 1, 0, "rnd_b");
      check("rnd_pos", och(0), 2);
      step(1, -1, -1, 1, 1, 0, "rnd_c");
      step(1, -2, -2, 1, 1, 0, "rnd_d");
      check("rnd_neg", och(0), -1);

      // Reset mid-FILL, clamped window, gapped input
      for (int i = 0; i < 10; i++) step(1, rand16(), rand16(), 7, 0, 0, "gap_pre");
      do_reset("mid_fill");
      for (int i = 0; i < 160; i++)
         step(($urandom_range(0, 1) == 1), rand16(), rand16(), 7, $urandom_range(0, 1), 0, "gap_fill");
      do_reset("mid_run");
      for (int i = 0; i < 140; i++)
         step(($urandom_range(0, 3) != 0), rand16(), rand16(), 7, $urandom_range(0, 1), 0, "gap_run");

      // Random traffic with occasional window changes and clears
      begin
         int len;
         len = 3;
         for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 99) < 3) len = $urandom_range(0, 7);
            step(($urandom_range(0, 9) < 7), rand16(), rand16(), len, $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 2), "rand");
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
